// File: rtl/sram_wrr_sched_pkg.sv
// Shared types and helpers for the SRAM weighted round-robin scheduler.
// Holds the FSM state encoding and a constant-time ceil-log2 used to size IDs and pointers.
package sram_wrr_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_t;

    // Ceil-log2 with a floor of 1 so a single-entry width never collapses to zero bits.
    function automatic int log2c(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sram_rd_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding read.
// Zero-latency head; push while full is dropped unless a pop frees the slot in the same cycle.
module sram_rd_tag_fifo
    import sram_wrr_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = log2c(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_wrr_sched.sv
// Weighted round-robin arbiter feeding one SRAM command port; read returns routed back via a tag FIFO.
// One command per two cycles at best; req held until req_ack, cmd_req held until cmd_ack, read data +1 cycle.
module sram_wrr_sched
    import sram_wrr_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 36,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_rd_wr_L,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*SRAM_DATA_WIDTH-1:0] req_wr_data,
    input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]    weight,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 rd_vld,
    output logic [SRAM_DATA_WIDTH-1:0]         rd_data,
    output logic                               cmd_req,
    output logic                               cmd_rd_wr_L,
    output logic [SRAM_ADDR_WIDTH-1:0]         cmd_addr,
    output logic [SRAM_DATA_WIDTH-1:0]         cmd_wr_data,
    input  logic                               cmd_ack,
    input  logic                               cmd_rd_vld,
    input  logic [SRAM_DATA_WIDTH-1:0]         cmd_rd_data,
    output logic                               tag_err
);
    localparam int ID_W = log2c(NUM_REQ);
    localparam int WW   = WEIGHT_WIDTH;

    sched_state_t               r_state;
    logic [ID_W-1:0]            r_owner;
    logic [WW-1:0]              r_credit;
    logic                       r_cmd_req;
    logic                       r_cmd_rd_wr_L;
    logic [SRAM_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [SRAM_DATA_WIDTH-1:0] r_cmd_wr_data;
    logic [NUM_REQ-1:0]         r_rd_vld;
    logic [SRAM_DATA_WIDTH-1:0] r_rd_data;
    logic                       r_tag_err;

    logic [NUM_REQ-1:0]         w_elig;
    logic                       w_keep;
    logic                       w_found;
    logic [ID_W-1:0]            w_winner;
    logic [ID_W-1:0]            w_sel;
    logic                       w_ack;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [ID_W-1:0]            w_tag_head;

    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = r_owner;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req[i] && (weight[i*WW +: WW] != '0) && !(req_rd_wr_L[i] && w_fifo_full);
        end
        // Walk offsets high to low so the nearest eligible requester after the owner wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = (int'(r_owner) + k) % NUM_REQ;
            if (w_elig[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_keep = w_elig[r_owner] && (r_credit != '0);
    assign w_sel  = w_keep ? r_owner : w_winner;
    assign w_ack  = (r_state == ST_BUSY) && cmd_ack && !reset;

    assign req_ack     = w_ack ? (NUM_REQ'(1) << r_owner) : '0;
    assign rd_vld      = r_rd_vld;
    assign rd_data     = r_rd_data;
    assign cmd_req     = r_cmd_req;
    assign cmd_rd_wr_L = r_cmd_rd_wr_L;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_wr_data = r_cmd_wr_data;
    assign tag_err     = r_tag_err;

    sram_rd_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_ack && r_cmd_rd_wr_L),
        .i_push_dat (r_owner),
        .i_pop      (cmd_rd_vld),
        .o_pop_dat  (w_tag_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= '0;
            r_credit      <= '0;
            r_cmd_req     <= 1'b0;
            r_cmd_rd_wr_L <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_wr_data <= '0;
            r_rd_vld      <= '0;
            r_rd_data     <= '0;
            r_tag_err     <= 1'b0;
        end else begin
            r_rd_vld <= '0;
            if (cmd_rd_vld) begin
                if (!w_fifo_empty) begin
                    r_rd_vld  <= NUM_REQ'(1) << w_tag_head;
                    r_rd_data <= cmd_rd_data;
                end else begin
                    r_tag_err <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_keep || w_found) begin
                        if (!w_keep) begin
                            r_owner  <= w_winner;
                            r_credit <= weight[int'(w_winner)*WW +: WW];
                        end
                        r_cmd_rd_wr_L <= req_rd_wr_L[w_sel];
                        r_cmd_addr    <= req_addr[int'(w_sel)*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
                        r_cmd_wr_data <= req_wr_data[int'(w_sel)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
                        r_cmd_req     <= 1'b1;
                        r_state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cmd_ack) begin
                        if (r_credit != '0) r_credit <= r_credit - WW'(1);
                        r_cmd_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wrr_sched.sv
// Directed bench for sram_wrr_sched: a responsive controller model plus requesters that drop
// their request after a set number of acks; expected grant orders and data are hand-derived.
module tb_sram_wrr_sched;
    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 36;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_rd_wr_L = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wr_data = '0;
    logic [N*WW-1:0] weight = '0;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    rd_vld;
    logic [DW-1:0]   rd_data;
    logic            cmd_req;
    logic            cmd_rd_wr_L;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wr_data;
    logic            cmd_ack = 1'b0;
    logic            cmd_rd_vld = 1'b0;
    logic [DW-1:0]   cmd_rd_data = '0;
    logic            tag_err;

    int checks = 0;
    int errors = 0;
    int rem[N];
    int grants[$];
    logic [AW-1:0] gaddr[$];
    logic auto_ack = 1'b0;

    sram_wrr_sched #(
        .NUM_REQ(N), .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW),
        .WEIGHT_WIDTH(WW), .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_rd_wr_L(req_rd_wr_L),
        .req_addr(req_addr), .req_wr_data(req_wr_data), .weight(weight),
        .req_ack(req_ack), .rd_vld(rd_vld), .rd_data(rd_data),
        .cmd_req(cmd_req), .cmd_rd_wr_L(cmd_rd_wr_L), .cmd_addr(cmd_addr),
        .cmd_wr_data(cmd_wr_data), .cmd_ack(cmd_ack), .cmd_rd_vld(cmd_rd_vld),
        .cmd_rd_data(cmd_rd_data), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: controller acks any pending command, requesters react to req_ack.
    task automatic cyc();
        @(posedge clk);
        #1;
        cmd_ack = auto_ack & cmd_req;
        #1;
        check("ack_onehot", 64'($onehot0(req_ack)), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                grants.push_back(i);
                gaddr.push_back(cmd_addr);
                if (rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        cmd_rd_vld = 1'b0;
        auto_ack = 1'b0;
        cmd_ack = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        grants.delete();
        gaddr.delete();
        for (int i = 0; i < N; i++) rem[i] = 0;
    endtask

    task automatic set_req(input int id, input logic rd, input logic [AW-1:0] addr, input int cnt);
        req_rd_wr_L[id] = rd;
        req_addr[id*AW +: AW] = addr;
        req_wr_data[id*DW +: DW] = DW'(36'hA_0000_0000 + id);
        rem[id] = cnt;
        req[id] = 1'b1;
    endtask

    function automatic int count_of(input int id);
        int c;
        c = 0;
        foreach (grants[k]) if (grants[k] == id) c++;
        return c;
    endfunction

    initial begin
        int exp1[10];
        int exp2[3];
        logic [DW-1:0] rdat[3];
        logic [N-1:0]  rvld[3];
        exp1 = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
        exp2 = '{1, 3, 0};
        rdat = '{36'h0_D000_0000, 36'h1_D111_1111, 36'h2_D222_2222};
        rvld = '{4'b0001, 4'b1000, 4'b0001};

        // Reset state
        do_reset();
        check("rst_cmd_req", 64'(cmd_req), 64'd0);
        check("rst_req_ack", 64'(req_ack), 64'd0);
        check("rst_rd_vld", 64'(rd_vld), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        check("rst_tag_err", 64'(tag_err), 64'd0);

        // 1: weights {1,2,3,4}, continuous writes, two-cycle rhythm
        weight = {4'd4, 4'd3, 4'd2, 4'd1};
        auto_ack = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(19'h100 + i), -1);
        run(40);
        check("t1_grant_count", 64'(grants.size()), 64'd20);
        for (int k = 0; k < 20 && k < grants.size(); k++)
            check("t1_order", 64'(grants[k]), 64'(exp1[k % 10]));
        check("t1_addr_first", 64'(gaddr[0]), 64'h101);

        // 2: requester 2 masked by zero weight
        do_reset();
        weight = {4'd1, 4'd0, 4'd1, 4'd1};
        auto_ack = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(19'h200 + i), -1);
        run(24);
        check("t2_grant_count", 64'(grants.size()), 64'd12);
        check("t2_req2_never", 64'(count_of(2)), 64'd0);
        for (int k = 0; k < 12 && k < grants.size(); k++)
            check("t2_order", 64'(grants[k]), 64'(exp2[k % 3]));

        // 3: tag FIFO fills, reads held back while writes proceed
        do_reset();
        weight = {4'd1, 4'd1, 4'd15, 4'd1};
        auto_ack = 1'b1;
        set_req(1, 1'b1, 19'h300, 8);
        run(16);
        check("t3_eight_reads", 64'(count_of(1)), 64'd8);
        set_req(1, 1'b1, 19'h308, 1);
        set_req(0, 1'b0, 19'h3F0, 1);
        run(8);
        check("t3_write_acked", 64'(count_of(0)), 64'd1);
        check("t3_ninth_held", 64'(count_of(1)), 64'd8);
        check("t3_cmd_idle", 64'(cmd_req), 64'd0);
        cmd_rd_data = 36'h1_2345_6789;
        cmd_rd_vld = 1'b1;
        cyc();
        cmd_rd_vld = 1'b0;
        check("t3_ret_vld", 64'(rd_vld), 64'b0010);
        check("t3_ret_data", 64'(rd_data), 64'h1_2345_6789);
        run(6);
        check("t3_ninth_issued", 64'(count_of(1)), 64'd9);
        check("t3_ninth_addr", 64'(gaddr[gaddr.size()-1]), 64'h308);

        // 4: interleaved reads routed back in issue order
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        auto_ack = 1'b1;
        set_req(0, 1'b1, 19'h10, 1);
        run(4);
        set_req(3, 1'b1, 19'h20, 1);
        run(4);
        set_req(0, 1'b1, 19'h30, 1);
        run(4);
        check("t4_grant_count", 64'(grants.size()), 64'd3);
        if (grants.size() == 3) begin
            check("t4_g0", 64'(grants[0]), 64'd0);
            check("t4_g1", 64'(grants[1]), 64'd3);
            check("t4_g2", 64'(grants[2]), 64'd0);
            check("t4_a1", 64'(gaddr[1]), 64'h20);
            check("t4_a2", 64'(gaddr[2]), 64'h30);
        end
        for (int k = 0; k < 3; k++) begin
            cmd_rd_data = rdat[k];
            cmd_rd_vld = 1'b1;
            cyc();
            check("t4_rd_vld", 64'(rd_vld), 64'(rvld[k]));
            check("t4_rd_data", 64'(rd_data), 64'(rdat[k]));
        end
        cmd_rd_vld = 1'b0;
        cyc();
        check("t4_rd_vld_drop", 64'(rd_vld), 64'd0);
        check("t4_no_tag_err", 64'(tag_err), 64'd0);

        // 5: return with no outstanding tag
        cmd_rd_data = 36'hF_FFFF_FFFF;
        cmd_rd_vld = 1'b1;
        cyc();
        cmd_rd_vld = 1'b0;
        check("t5_no_rd_vld", 64'(rd_vld), 64'd0);
        check("t5_tag_err", 64'(tag_err), 64'd1);
        run(3);
        check("t5_tag_err_sticky", 64'(tag_err), 64'd1);

        // 6: reset while a read command is pending
        do_reset();
        check("t6_tag_err_clr", 64'(tag_err), 64'd0);
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        set_req(1, 1'b1, 19'h40, 1);
        cyc();
        check("t6_busy", 64'(cmd_req), 64'd1);
        reset = 1'b1;
        cmd_ack = 1'b1;
        #1;
        check("t6_no_ack_in_reset", 64'(req_ack), 64'd0);
        auto_ack = 1'b1;
        cyc();
        check("t6_cmd_req_drop", 64'(cmd_req), 64'd0);
        check("t6_ack_zero", 64'(req_ack), 64'd0);
        reset = 1'b0;
        grants.delete();
        gaddr.delete();
        req = '0;
        set_req(0, 1'b0, 19'h50, 1);
        set_req(1, 1'b0, 19'h51, 1);
        run(6);
        check("t6_restart_count", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("t6_first_is_1", 64'(grants[0]), 64'd1);
            check("t6_second_is_0", 64'(grants[1]), 64'd0);
        end
        cmd_rd_vld = 1'b1;
        cyc();
        cmd_rd_vld = 1'b0;
        check("t6_fifo_empty_rd_vld", 64'(rd_vld), 64'd0);
        check("t6_fifo_empty_err", 64'(tag_err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
